neuron_sample_feeder: RTL and testbench
=======================================

# neuron_sample_feeder

Drives the training side of the two-input neuron. It holds a local table of up to DEPTH training samples, starts a training run, and streams the samples onto the neuron's sample buses one per data request, wrapping into repeated epochs until the neuron reports done. It then captures the trained weights and bias into result registers. It sits between the host/testbench write port and the neuron training unit.

## Interface
- DEPTH, 32, maximum number of stored samples
- ADDR_W, 5, sample address width, log2(DEPTH)
- MAX_EPOCHS, 255, epoch limit before timeout abort; range 1..65535

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- wrEn  in  1  write sample table entry; honoured only in IDLE/DONE
- wrAddr  in  ADDR_W  table address
- wrX1, wrX2  in  7  sample inputs, stored raw
- wrT  in  2  target, stored raw (01 = +1, 11 = −1)
- sampleCount  in  ADDR_W+1  number of valid samples n, sampled on go
- go  in  1  start a training run
- X1Bus, X2Bus  out  7  current sample to neuron
- tBus  out  2  current target to neuron
- nBus  out  32  latched n, zero-extended
- start  out  1  one-cycle start pulse to neuron
- readyToGetData  in  1  neuron consumes current sample at this edge
- done  in  1  neuron training finished
- W1, W2, Bias  in  14  neuron weights
- W1Out, W2Out, BiasOut  out  14  captured results
- busy  out  1  run in progress (START or FEED)
- resultValid  out  1  captured results valid
- timeout  out  1  run aborted at MAX_EPOCHS

## Operation
- States: IDLE, START, FEED, DONE.
- IDLE: go=1 with 1 ≤ sampleCount ≤ DEPTH → latch n, idx=0, epoch=0, → START. go with sampleCount=0 or >DEPTH ignored.
- START: start=1 for this single cycle; → FEED.
- FEED: X1Bus/X2Bus/tBus = table[idx] (combinational read of registered idx). On an edge with readyToGetData=1: if idx=n−1 then idx←0, epoch←epoch+1, else idx←idx+1.
- Epoch limit: wrap edge taking epoch to MAX_EPOCHS → capture W1/W2/Bias, timeout←1, → DONE.
- done=1 in FEED → capture W1/W2/Bias, → DONE; done has priority over readyToGetData and the epoch limit on the same edge; idx not advanced.
- DONE: resultValid=1; results held. go (valid sampleCount) → clear resultValid/timeout, restart as from IDLE.
- wrEn in START/FEED ignored (table unchanged). wrEn and go on the same edge in IDLE/DONE: the write completes; the run sees the new entry.
- done or readyToGetData outside FEED ignored.
- Outside FEED, X1Bus/X2Bus/tBus show table[idx] (idx holds last value; 0 after reset).

## Timing
- Reset (async): state IDLE, idx=0, epoch=0, n=0, start=0, busy=0, resultValid=0, timeout=0, W1Out=W2Out=BiasOut=0, nBus=0; table contents undefined.
- go at edge k → start=1 and busy=1 during cycle k..k+1; nBus valid from k; sample 0 on buses from k.
- Consume edge j → next sample on buses from j (visible cycle after j).
- done at edge d → W1Out/W2Out/BiasOut = W1/W2/Bias sampled at d; resultValid=1, busy=0 from d.
- rst mid-run: immediate return to reset values; neuron sees start=0.

## Test plan
- Reset mid-FEED (idx=2, epoch=1): assert rst → all outputs at reset values the same cycle; subsequent readyToGetData ignored.
- Load 4 samples, n=4, go → start high exactly one cycle, nBus=4; eight readyToGetData pulses → buses show samples 0,1,2,3,0,1,2,3 in order, epoch=2.
- n=1 → every readyToGetData re-presents sample 0, epoch increments per pulse.
- done and readyToGetData on the same edge with W1=14'h0123, W2=14'h3F00, Bias=14'h0005 → W1Out/W2Out/BiasOut equal these, resultValid=1, idx unchanged, timeout=0.
- MAX_EPOCHS=2, n=3, done never asserted → after 6th consume: DONE, timeout=1, resultValid=1; go with sampleCount=0 in DONE → ignored.
- wrEn during FEED to address 0 → table entry 0 unchanged on next epoch; same write in DONE → new value presented after next go.

Source files
------------

// File: rtl/neuron_sample_feeder.sv
// neuron_sample_feeder
// Holds up to DEPTH training samples and streams them to the two-input neuron,
// one per data request, wrapping into epochs until the neuron reports done or
// the epoch limit is reached. The final weights and bias are then captured.
module neuron_sample_feeder #(
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = 5,
    parameter int MAX_EPOCHS = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [6:0]        wrX1,
    input  logic [6:0]        wrX2,
    input  logic [1:0]        wrT,
    input  logic [ADDR_W:0]   sampleCount,
    input  logic              go,
    output logic [6:0]        X1Bus,
    output logic [6:0]        X2Bus,
    output logic [1:0]        tBus,
    output logic [31:0]       nBus,
    output logic              start,
    input  logic              readyToGetData,
    input  logic              done,
    input  logic [13:0]       W1,
    input  logic [13:0]       W2,
    input  logic [13:0]       Bias,
    output logic [13:0]       W1Out,
    output logic [13:0]       W2Out,
    output logic [13:0]       BiasOut,
    output logic              busy,
    output logic              resultValid,
    output logic              timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_FEED,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C     = (ADDR_W+1)'(DEPTH);
    localparam logic [15:0]     MAX_EPOCH_C = 16'(MAX_EPOCHS);

    // Sample table entry: {x1, x2, t}
    logic [15:0] table_mem [DEPTH];

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [15:0]         epoch_q, epoch_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic [13:0]         w1_q, w1_d;
    logic [13:0]         w2_q, w2_d;
    logic [13:0]         bias_q, bias_d;
    logic                timeout_q, timeout_d;

    logic                idle_like;
    logic                go_ok;
    logic                last_sample;
    logic [15:0]         epoch_inc;

    assign idle_like   = (state_q == S_IDLE) || (state_q == S_DONE);
    assign go_ok       = go && (sampleCount != '0) && (sampleCount <= DEPTH_C);
    assign last_sample = (idx_q == ADDR_W'(n_q - 1'b1));
    assign epoch_inc   = epoch_q + 16'd1;

    // Table write port, open only while no run is in progress.
    // NOTE: the sample table carries no reset; its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (wrEn && idle_like) begin
            table_mem[wrAddr] <= {wrX1, wrX2, wrT};
        end
    end

    // State and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            epoch_q   <= '0;
            n_q       <= '0;
            w1_q      <= '0;
            w2_q      <= '0;
            bias_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            epoch_q   <= epoch_d;
            n_q       <= n_d;
            w1_q      <= w1_d;
            w2_q      <= w2_d;
            bias_q    <= bias_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: run start, sample advance, epoch wrap and result capture.
    // NOTE: every variable gets a hold default first so no path leaves a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        epoch_d   = epoch_q;
        n_d       = n_q;
        w1_d      = w1_q;
        w2_d      = w2_q;
        bias_d    = bias_q;
        timeout_d = timeout_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (go_ok) begin
                    n_d       = sampleCount;
                    idx_d     = '0;
                    epoch_d   = '0;
                    timeout_d = 1'b0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                state_d = S_FEED;
            end
            S_FEED: begin
                if (done) begin
                    // Neuron finished: capture and leave idx where it is.
                    w1_d    = W1;
                    w2_d    = W2;
                    bias_d  = Bias;
                    state_d = S_DONE;
                end else if (readyToGetData) begin
                    if (last_sample) begin
                        idx_d   = '0;
                        epoch_d = epoch_inc;
                        if (epoch_inc == MAX_EPOCH_C) begin
                            w1_d      = W1;
                            w2_d      = W2;
                            bias_d    = Bias;
                            timeout_d = 1'b1;
                            state_d   = S_DONE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign {X1Bus, X2Bus, tBus} = table_mem[idx_q];
    assign nBus        = {{(32-ADDR_W-1){1'b0}}, n_q};
    assign start       = (state_q == S_START);
    assign busy        = (state_q == S_START) || (state_q == S_FEED);
    assign resultValid = (state_q == S_DONE);
    assign timeout     = timeout_q;
    assign W1Out       = w1_q;
    assign W2Out       = w2_q;
    assign BiasOut     = bias_q;

endmodule

// File: tb/tb_neuron_sample_feeder.sv
// Directed bench for neuron_sample_feeder. A second instance with a small
// epoch limit shares the stimulus and makes the epoch count observable.
module tb_neuron_sample_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrEn;
    logic [4:0]  wrAddr;
    logic [6:0]  wrX1, wrX2;
    logic [1:0]  wrT;
    logic [5:0]  sampleCount;
    logic        go;
    logic        readyToGetData;
    logic        done;
    logic [13:0] W1, W2, Bias;

    logic [6:0]  X1Bus, X2Bus;
    logic [1:0]  tBus;
    logic [31:0] nBus;
    logic        start, busy, resultValid, timeout;
    logic [13:0] W1Out, W2Out, BiasOut;

    logic [6:0]  t_X1Bus, t_X2Bus;
    logic [1:0]  t_tBus;
    logic [31:0] t_nBus;
    logic        t_start, t_busy, t_resultValid, t_timeout;
    logic [13:0] t_W1Out, t_W2Out, t_BiasOut;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] sx1 [4];
    logic [6:0] sx2 [4];
    logic [1:0] st  [4];

    typedef struct {
        logic ready;
        int   pre;
        int   post;
        logic exp_to;
    } vec_t;
    vec_t v [10];

    always #5 clk = ~clk;

    neuron_sample_feeder dut (
        .clk(clk), .rst(rst), .wrEn(wrEn), .wrAddr(wrAddr), .wrX1(wrX1), .wrX2(wrX2),
        .wrT(wrT), .sampleCount(sampleCount), .go(go), .X1Bus(X1Bus), .X2Bus(X2Bus),
        .tBus(tBus), .nBus(nBus), .start(start), .readyToGetData(readyToGetData),
        .done(done), .W1(W1), .W2(W2), .Bias(Bias), .W1Out(W1Out), .W2Out(W2Out),
        .BiasOut(BiasOut), .busy(busy), .resultValid(resultValid), .timeout(timeout)
    );

    neuron_sample_feeder #(.MAX_EPOCHS(2)) dut_t (
        .clk(clk), .rst(rst), .wrEn(wrEn), .wrAddr(wrAddr), .wrX1(wrX1), .wrX2(wrX2),
        .wrT(wrT), .sampleCount(sampleCount), .go(go), .X1Bus(t_X1Bus), .X2Bus(t_X2Bus),
        .tBus(t_tBus), .nBus(t_nBus), .start(t_start), .readyToGetData(readyToGetData),
        .done(1'b0), .W1(W1), .W2(W2), .Bias(Bias), .W1Out(t_W1Out), .W2Out(t_W2Out),
        .BiasOut(t_BiasOut), .busy(t_busy), .resultValid(t_resultValid), .timeout(t_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_bus(input string name, input int i);
        check(name, {16'd0, X1Bus, X2Bus, tBus}, {16'd0, sx1[i], sx2[i], st[i]});
    endtask

    task automatic wr(input logic [4:0] a, input logic [6:0] x1, input logic [6:0] x2,
                      input logic [1:0] t);
        wrEn = 1'b1; wrAddr = a; wrX1 = x1; wrX2 = x2; wrT = t;
        tick();
        wrEn = 1'b0;
    endtask

    task automatic pulse_ready();
        readyToGetData = 1'b1;
        tick();
        readyToGetData = 1'b0;
    endtask

    task automatic launch(input logic [5:0] n);
        sampleCount = n; go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    initial begin
        sx1 = '{7'h11, 7'h22, 7'h33, 7'h44};
        sx2 = '{7'h05, 7'h7F, 7'h40, 7'h01};
        st  = '{2'b01, 2'b11, 2'b01, 2'b11};

        // Consume pattern for n=4 with idle gaps: bus before, bus after, limit-2 timeout after.
        v[0] = '{1'b1, 0, 1, 1'b0};
        v[1] = '{1'b0, 1, 1, 1'b0};
        v[2] = '{1'b1, 1, 2, 1'b0};
        v[3] = '{1'b1, 2, 3, 1'b0};
        v[4] = '{1'b1, 3, 0, 1'b0};
        v[5] = '{1'b1, 0, 1, 1'b0};
        v[6] = '{1'b0, 1, 1, 1'b0};
        v[7] = '{1'b1, 1, 2, 1'b0};
        v[8] = '{1'b1, 2, 3, 1'b0};
        v[9] = '{1'b1, 3, 0, 1'b1};

        rst = 1'b1; wrEn = 1'b0; wrAddr = '0; wrX1 = '0; wrX2 = '0; wrT = '0;
        sampleCount = '0; go = 1'b0; readyToGetData = 1'b0; done = 1'b0;
        W1 = '0; W2 = '0; Bias = '0;
        #1;
        check("rst start", start, 0);
        check("rst busy", busy, 0);
        check("rst resultValid", resultValid, 0);
        check("rst timeout", timeout, 0);
        check("rst nBus", nBus, 0);
        check("rst W1Out", W1Out, 0);
        check("rst BiasOut", BiasOut, 0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 4; i++) wr(5'(i), sx1[i], sx2[i], st[i]);

        // Invalid go requests stay in IDLE.
        launch(6'd33);
        check("go n=33 ignored", busy, 0);
        launch(6'd0);
        check("go n=0 ignored", busy, 0);

        // Reset in the middle of FEED at idx=2, epoch=1.
        launch(6'd4);
        tick();
        for (int i = 0; i < 6; i++) pulse_ready();
        check_bus("pre-reset idx2", 2);
        rst = 1'b1;
        #1;
        check("midrun rst start", start, 0);
        check("midrun rst busy", busy, 0);
        check("midrun rst nBus", nBus, 0);
        check("midrun rst resultValid", resultValid, 0);
        check_bus("midrun rst idx0", 0);
        readyToGetData = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        readyToGetData = 1'b0;
        check("post-rst ready ignored busy", busy, 0);
        check_bus("post-rst ready ignored bus", 0);

        // n=4 streaming through two epochs.
        launch(6'd4);
        check("go start high", start, 1);
        check("go busy", busy, 1);
        check("go nBus", nBus, 4);
        check_bus("go sample0", 0);
        tick();
        check("start one cycle", start, 0);
        check("feed busy", busy, 1);
        for (int i = 0; i < 10; i++) begin
            check_bus($sformatf("vec%0d pre", i), v[i].pre);
            readyToGetData = v[i].ready;
            tick();
            readyToGetData = 1'b0;
            check_bus($sformatf("vec%0d post", i), v[i].post);
            check($sformatf("vec%0d epoch limit", i), t_timeout, v[i].exp_to);
        end
        check("n4 main still busy", busy, 1);
        check("n4 main no timeout", timeout, 0);

        // done and readyToGetData on the same edge.
        pulse_ready();
        W1 = 14'h0123; W2 = 14'h3F00; Bias = 14'h0005;
        done = 1'b1; readyToGetData = 1'b1;
        tick();
        done = 1'b0; readyToGetData = 1'b0;
        W1 = '0; W2 = '0; Bias = '0;
        check("done W1Out", W1Out, 14'h0123);
        check("done W2Out", W2Out, 14'h3F00);
        check("done BiasOut", BiasOut, 14'h0005);
        check("done resultValid", resultValid, 1);
        check("done busy", busy, 0);
        check("done timeout", timeout, 0);
        check_bus("done idx held", 1);

        // n=1: every request re-presents sample 0 and closes an epoch.
        launch(6'd1);
        check("n1 limit inst cleared rv", t_resultValid, 0);
        check("n1 limit inst cleared to", t_timeout, 0);
        check("n1 nBus", nBus, 1);
        tick();
        for (int p = 1; p <= 3; p++) begin
            pulse_ready();
            check_bus($sformatf("n1 pulse%0d bus", p), 0);
            check($sformatf("n1 pulse%0d busy", p), busy, 1);
            check($sformatf("n1 pulse%0d epoch limit", p), t_timeout, (p >= 2));
        end
        done = 1'b1;
        tick();
        done = 1'b0;

        // Epoch-limit abort with n=3 on the MAX_EPOCHS=2 instance.
        W1 = 14'h1555; W2 = 14'h0AAA; Bias = 14'h3FFF;
        launch(6'd3);
        tick();
        for (int p = 1; p <= 6; p++) begin
            pulse_ready();
            check($sformatf("to pulse%0d timeout", p), t_timeout, (p == 6));
            check($sformatf("to pulse%0d resultValid", p), t_resultValid, (p == 6));
        end
        check("to W1Out", t_W1Out, 14'h1555);
        check("to W2Out", t_W2Out, 14'h0AAA);
        check("to BiasOut", t_BiasOut, 14'h3FFF);
        W1 = '0; W2 = '0; Bias = '0;
        launch(6'd0);
        check("to go n=0 rv held", t_resultValid, 1);
        check("to go n=0 no start", t_start, 0);
        check("to go n=0 timeout held", t_timeout, 1);
        check("to go n=0 W1Out held", t_W1Out, 14'h1555);

        // Writes during FEED are dropped; writes in DONE take effect on the next run.
        wr(5'd0, 7'h7E, 7'h3C, 2'b11);
        check_bus("feed write dropped", 0);
        for (int i = 0; i < 3; i++) pulse_ready();
        check_bus("feed write dropped next epoch", 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        wrEn = 1'b1; wrAddr = 5'd0; wrX1 = 7'h7E; wrX2 = 7'h3C; wrT = 2'b11;
        sampleCount = 6'd3; go = 1'b1;
        tick();
        wrEn = 1'b0; go = 1'b0;
        check("write+go start", start, 1);
        check("write+go new entry", {16'd0, X1Bus, X2Bus, tBus}, {16'd0, 7'h7E, 7'h3C, 2'b11});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
